cacheline_adaptor: RTL and testbench
====================================

Name: cacheline_adaptor

Overview:
- Converts one full-cache-line request from the cache controller into a multi-beat burst on the physical memory bus.
- Sits directly downstream of the cache control/datapath, driven by its pmem_read/pmem_write signals.
- Deserialises read bursts into line_o and serialises line_i into write bursts.
- Returns a single-cycle resp_o per completed line transaction.

Parameters:
- LINE_W, 256, cache line width in bits.
- BURST_W, 64, memory bus beat width in bits. BEATS = LINE_W/BURST_W must be a power of two and at least 2.
- ADDR_W, 32, byte address width.

Ports:
- clk  input  1  clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- address_i  input  ADDR_W  line address from the cache.
- read_i  input  1  line read request, held by the cache until resp_o.
- write_i  input  1  line write-back request, held by the cache until resp_o.
- line_i  input  LINE_W  write-back line data.
- line_o  output  LINE_W  assembled read line.
- resp_o  output  1  line transaction complete; one-cycle pulse.
- address_o  output  ADDR_W  burst address to memory.
- burst_i  input  BURST_W  read beat data, qualified by resp_i.
- burst_o  output  BURST_W  write beat data.
- read_o  output  1  memory read request.
- write_o  output  1  memory write request.
- resp_i  input  1  memory accepted or returned one beat this cycle.

Behaviour:
- Reset values: state IDLE, beat counter 0, read_o 0, write_o 0, resp_o 0, address_o 0, burst_o 0, line_o 0.
- Reset taken mid-transaction aborts it; the adaptor returns to IDLE with read_o and write_o low on the next cycle, and partial line_o contents are cleared. The memory model is reset together with the adaptor.
- States: IDLE, READ, WRITE, DONE. Outputs are Moore, decoded from registered state.
- IDLE:
  - write_i=1 -> latch address_i and line_i, clear the counter, go to WRITE.
  - Otherwise read_i=1 -> latch address_i, clear the counter, go to READ.
  - Write wins if both are high.
  - Neither high -> stay in IDLE.
- READ:
  - read_o=1 and address_o=latched address.
  - On each cycle with resp_i=1, burst_i is stored into line_o slice [BURST_W*k +: BURST_W], where k is the counter; the counter then increments.
  - Beat 0 is line bits [BURST_W-1:0] (little-endian beat order).
  - Beats need not be consecutive; cycles with resp_i=0 change nothing.
  - On the resp_i cycle where k = BEATS-1 -> go to DONE. read_o drops the next cycle.
- WRITE:
  - write_o=1, address_o=latched address, burst_o=latched line slice k.
  - Each resp_i=1 advances k, and burst_o presents the next slice the following cycle.
  - Last beat -> go to DONE.
- DONE:
  - resp_o=1 for exactly one cycle; read_o=0, write_o=0; read_i and write_i are ignored.
  - Next state is always IDLE.
  - A request still high in IDLE starts a new transaction, so the cache must drop its request in the cycle after resp_o.
- Latency:
  - Request seen in IDLE at cycle 0 -> read_o/write_o high from cycle 1.
  - With resp_i high in cycles 1-4 -> resp_o high in cycle 5.
  - Minimum line latency is 5 cycles.
- line_o holds the last completed read line until the next read begins overwriting slices. It is not cleared by writes.
- The counter width is log2(BEATS) and is never allowed to wrap within a transaction. resp_i in IDLE or DONE is ignored.
- address_o and burst_o remain stable while read_o/write_o are high and resp_i is low.

Optional Feature:
- ADAPTOR_ALIGN_EN defined: the latched address has its low log2(LINE_W/8) bits forced to 0, so address_o is always line-aligned.
- Undefined: address_i is passed through unmodified, and the cache is responsible for alignment.

Test Plan:
- Read, 4 back-to-back beats: address_i=0x0000_1040, read_i held, resp_i cycles 1-4 with burst_i=0x11..11, 0x22..22, 0x33..33, 0x44..44. Required: read_o cycles 1-4, address_o=0x1040, resp_o only in cycle 5, line_o={0x44..,0x33..,0x22..,0x11..}.
- Read with stalls: resp_i pattern 1,0,0,1,1,0,1. Required: each beat lands in the correct slice, read_o stays high through the stalls, resp_o is one cycle after the 4th beat.
- Write-back: line_i=256'h0123…CDEF, address_i=0x2000. Required: burst_o equals slices 0..3 in order, one per resp_i, write_o drops after beat 3, resp_o pulses once, line_o unchanged.
- Simultaneous read_i=1 and write_i=1 in IDLE: required WRITE first; after resp_o and IDLE, a still-held read_i starts READ.
- rst asserted after 2 read beats: required read_o=0 and state IDLE next cycle, no resp_o. A fresh read afterwards completes normally.
- With ADAPTOR_ALIGN_EN, address_i=0x1047 gives address_o=0x1040. Without it, address_o=0x1047.

Source files
------------

// File: rtl/cacheline_adaptor.sv
// Cache line <-> memory burst adaptor: deserialises read bursts into a line and
// serialises a write-back line into beats. ADAPTOR_ALIGN_EN forces line-aligned addresses.
module cacheline_adaptor #(
    parameter int unsigned LINE_W  = 256,
    parameter int unsigned BURST_W = 64,
    parameter int unsigned ADDR_W  = 32
) (
    input  logic               clk,
    input  logic               rst,
    // cache side
    input  logic [ADDR_W-1:0]  address_i,
    input  logic               read_i,
    input  logic               write_i,
    input  logic [LINE_W-1:0]  line_i,
    output logic [LINE_W-1:0]  line_o,
    output logic               resp_o,
    // memory side
    output logic [ADDR_W-1:0]  address_o,
    input  logic [BURST_W-1:0] burst_i,
    output logic [BURST_W-1:0] burst_o,
    output logic               read_o,
    output logic               write_o,
    input  logic               resp_i
);

    localparam int unsigned BEATS = LINE_W / BURST_W;
    localparam int unsigned CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    // Reject geometries the beat counter cannot express exactly.
    generate
        if (BEATS < 2 || (BEATS & (BEATS - 1)) != 0 || (LINE_W % BURST_W) != 0) begin : g_bad_cfg
            $error("cacheline_adaptor: LINE_W/BURST_W must be a power of two >= 2");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_e;

    state_e                          state_q, state_d;
    logic [CNT_W-1:0]                cnt_q, cnt_d;
    logic [ADDR_W-1:0]               addr_q, addr_d;
    logic [BEATS-1:0][BURST_W-1:0]   wline_q, wline_d;
    logic [BEATS-1:0][BURST_W-1:0]   rline_q, rline_d;
    logic [BURST_W-1:0]              burst_q, burst_d;
    logic                            read_q, read_d;
    logic                            write_q, write_d;
    logic                            resp_q, resp_d;
    logic                            last_beat_c;
    logic [ADDR_W-1:0]               addr_in_c;

`ifdef ADAPTOR_ALIGN_EN
    localparam int unsigned OFF_W = $clog2(LINE_W / 8);
    assign addr_in_c = {address_i[ADDR_W-1:OFF_W], OFF_W'(0)};
`else
    assign addr_in_c = address_i;
`endif

    assign last_beat_c = (cnt_q == CNT_W'(BEATS - 1));

    // Next-state, datapath and Moore output decode from the next state.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wline_d = wline_q;
        rline_d = rline_q;
        burst_d = burst_q;

        case (state_q)
            IDLE: begin
                if (write_i) begin
                    addr_d  = addr_in_c;
                    wline_d = line_i;
                    cnt_d   = '0;
                    state_d = WRITE;
                end else if (read_i) begin
                    addr_d  = addr_in_c;
                    cnt_d   = '0;
                    state_d = READ;
                end
            end
            READ: begin
                if (resp_i) begin
                    rline_d[cnt_q] = burst_i;
                    if (last_beat_c) begin
                        state_d = DONE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            WRITE: begin
                if (resp_i) begin
                    if (last_beat_c) begin
                        state_d = DONE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        read_d  = (state_d == READ);
        write_d = (state_d == WRITE);
        resp_d  = (state_d == DONE);
        // Present the beat the memory will see in the coming WRITE cycle.
        if (state_d == WRITE) begin
            burst_d = wline_d[cnt_d];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wline_q <= '0;
            rline_q <= '0;
            burst_q <= '0;
            read_q  <= 1'b0;
            write_q <= 1'b0;
            resp_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wline_q <= wline_d;
            rline_q <= rline_d;
            burst_q <= burst_d;
            read_q  <= read_d;
            write_q <= write_d;
            resp_q  <= resp_d;
        end
    end

    assign line_o    = rline_q;
    assign resp_o    = resp_q;
    assign address_o = addr_q;
    assign burst_o   = burst_q;
    assign read_o    = read_q;
    assign write_o   = write_q;

endmodule

// File: tb/tb_cacheline_adaptor.sv
// Scoreboard bench for cacheline_adaptor: expected lines/beats are queued at request
// time and consumed by a negedge monitor as the adaptor produces them.
module tb_cacheline_adaptor;

    localparam int unsigned LINE_W  = 256;
    localparam int unsigned BURST_W = 64;
    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned BEATS   = LINE_W / BURST_W;

    logic               clk = 1'b0;
    logic               rst;
    logic [ADDR_W-1:0]  address_i;
    logic               read_i;
    logic               write_i;
    logic [LINE_W-1:0]  line_i;
    logic [LINE_W-1:0]  line_o;
    logic               resp_o;
    logic [ADDR_W-1:0]  address_o;
    logic [BURST_W-1:0] burst_i;
    logic [BURST_W-1:0] burst_o;
    logic               read_o;
    logic               write_o;
    logic               resp_i;

    cacheline_adaptor #(
        .LINE_W  (LINE_W),
        .BURST_W (BURST_W),
        .ADDR_W  (ADDR_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .address_i (address_i),
        .read_i    (read_i),
        .write_i   (write_i),
        .line_i    (line_i),
        .line_o    (line_o),
        .resp_o    (resp_o),
        .address_o (address_o),
        .burst_i   (burst_i),
        .burst_o   (burst_o),
        .read_o    (read_o),
        .write_o   (write_o),
        .resp_i    (resp_i)
    );

    always #5 clk = ~clk;

    int n_chk    = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int resp_cnt = 0;
    int resp_cyc = 0;
    bit mon_en   = 1'b0;

    logic [LINE_W-1:0]  exp_line_q[$];
    logic [BURST_W-1:0] exp_beat_q[$];
    logic [ADDR_W-1:0]  exp_addr;
    logic [LINE_W-1:0]  last_line;

    task automatic chk(input string tag, input logic [LINE_W-1:0] got, input logic [LINE_W-1:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [ADDR_W-1:0] exp_align(input logic [ADDR_W-1:0] a);
`ifdef ADAPTOR_ALIGN_EN
        return a & ~ADDR_W'(32'h1F);
`else
        return a;
`endif
    endfunction

    function automatic logic [LINE_W-1:0] rand_line();
        logic [LINE_W-1:0] l;
        for (int j = 0; j < LINE_W / 32; j++) l[j*32 +: 32] = $urandom();
        return l;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: address/beat stability every busy cycle, line at each resp_o.
    always @(negedge clk) begin
        if (mon_en) begin
            if (read_o || write_o) chk("address_o", LINE_W'(address_o), LINE_W'(exp_addr));
            if (write_o) begin
                if (exp_beat_q.size() == 0) begin
                    chk("beat_underflow", LINE_W'(1), LINE_W'(0));
                end else begin
                    chk("burst_o", LINE_W'(burst_o), LINE_W'(exp_beat_q[0]));
                    if (resp_i) void'(exp_beat_q.pop_front());
                end
            end
            if (resp_o) begin
                resp_cnt++;
                resp_cyc = cyc;
                if (exp_line_q.size() == 0) chk("resp_unexpected", LINE_W'(1), LINE_W'(0));
                else chk("line_o", line_o, exp_line_q.pop_front());
            end
        end
    end

    task automatic run_txn(input bit rd, input bit wr, input bit keep_rd,
                           input logic [ADDR_W-1:0] addr, input logic [LINE_W-1:0] data,
                           input logic [15:0] pat, input int lat);
        int k;
        int i;
        int t0;
        int r0;
        int guard;
        exp_addr = exp_align(addr);
        if (wr) begin
            for (int b = 0; b < BEATS; b++) exp_beat_q.push_back(data[b*BURST_W +: BURST_W]);
            exp_line_q.push_back(last_line);
            line_i = data;
        end else begin
            exp_line_q.push_back(data);
            line_i = rand_line();
        end
        address_i = addr;
        read_i    = rd;
        write_i   = wr;
        t0 = cyc;
        r0 = resp_cnt;
        guard = 0;
        do begin
            @(posedge clk); #1;
            guard++;
        end while (!(read_o || write_o) && guard < 20);
        if (guard >= 20) begin
            chk("start_timeout", LINE_W'(1), LINE_W'(0));
            read_i = 1'b0; write_i = 1'b0;
            exp_line_q.delete(); exp_beat_q.delete();
            return;
        end
        chk("write_o_kind", LINE_W'(write_o), LINE_W'(wr));
        chk("read_o_kind", LINE_W'(read_o), LINE_W'(!wr));
        k = 0;
        i = 0;
        while (k < BEATS && i < 64) begin
            chk("req_held", LINE_W'(wr ? write_o : read_o), LINE_W'(1));
            resp_i  = (i < 16) ? pat[4'(i)] : 1'b1;
            burst_i = resp_i ? data[k*BURST_W +: BURST_W] : {$urandom(), $urandom()};
            if (resp_i) k++;
            i++;
            @(posedge clk); #1;
        end
        resp_i  = 1'b0;
        burst_i = {$urandom(), $urandom()};
        chk("req_drop", LINE_W'(read_o | write_o), LINE_W'(0));
        chk("resp_o_high", LINE_W'(resp_o), LINE_W'(1));
        @(negedge clk);
        read_i  = keep_rd;
        write_i = 1'b0;
        @(posedge clk); #1;
        chk("resp_o_low", LINE_W'(resp_o), LINE_W'(0));
        @(negedge clk);
        chk("resp_pulses", LINE_W'(resp_cnt - r0), LINE_W'(1));
        if (lat > 0) chk("latency", LINE_W'(resp_cyc - t0), LINE_W'(lat));
        if (!wr) last_line = data;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [LINE_W-1:0] d;
        int r0;
        int guard;
        rst = 1'b1; read_i = 1'b0; write_i = 1'b0; resp_i = 1'b0;
        address_i = '0; line_i = '0; burst_i = '0;
        last_line = '0;
        exp_addr = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_read_o", LINE_W'(read_o), LINE_W'(0));
        chk("rst_write_o", LINE_W'(write_o), LINE_W'(0));
        chk("rst_resp_o", LINE_W'(resp_o), LINE_W'(0));
        chk("rst_address_o", LINE_W'(address_o), LINE_W'(0));
        chk("rst_burst_o", LINE_W'(burst_o), LINE_W'(0));
        chk("rst_line_o", line_o, LINE_W'(0));
        mon_en = 1'b1;
        @(negedge clk);

        // Back-to-back read, minimum latency.
        d = {{4{16'h4444}}, {4{16'h3333}}, {4{16'h2222}}, {4{16'h1111}}};
        run_txn(1'b1, 1'b0, 1'b0, 32'h0000_1040, d, 16'hFFFF, 5);

        // Read with stalls 1,0,0,1,1,0,1.
        run_txn(1'b1, 1'b0, 1'b0, 32'h0000_3000, rand_line(), 16'h0059, 0);

        // Write-back; line_o must stay at the last read line.
        d = 256'h0123456789abcdef_fedcba9876543210_a5a5a5a55a5a5a5a_13579bdf2468cdef;
        run_txn(1'b0, 1'b1, 1'b0, 32'h0000_2000, d, 16'hFFFF, 5);

        // Both requests: write first, then held read starts a read.
        run_txn(1'b1, 1'b1, 1'b1, 32'h0000_4000, rand_line(), 16'h00F5, 0);
        run_txn(1'b1, 1'b0, 1'b0, 32'h0000_4000, rand_line(), 16'hFFFF, 0);

        // resp_i in IDLE is ignored.
        r0 = resp_cnt;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            resp_i  = 1'b1;
            burst_i = {$urandom(), $urandom()};
        end
        @(posedge clk); #1;
        resp_i = 1'b0;
        chk("idle_line_o", line_o, last_line);
        chk("idle_busy", LINE_W'(read_o | write_o), LINE_W'(0));
        @(negedge clk);
        chk("idle_resp", LINE_W'(resp_cnt - r0), LINE_W'(0));

        // Reset after two read beats.
        exp_addr  = exp_align(32'h0000_5000);
        address_i = 32'h0000_5000;
        read_i    = 1'b1;
        guard = 0;
        do begin
            @(posedge clk); #1;
            guard++;
        end while (!read_o && guard < 20);
        chk("rst_txn_start", LINE_W'(read_o), LINE_W'(1));
        for (int b = 0; b < 2; b++) begin
            resp_i  = 1'b1;
            burst_i = {$urandom(), $urandom()};
            @(posedge clk); #1;
        end
        resp_i = 1'b0;
        rst    = 1'b1;
        read_i = 1'b0;
        r0 = resp_cnt;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_read_o", LINE_W'(read_o), LINE_W'(0));
        chk("abort_write_o", LINE_W'(write_o), LINE_W'(0));
        chk("abort_resp_o", LINE_W'(resp_o), LINE_W'(0));
        chk("abort_line_o", line_o, LINE_W'(0));
        last_line = '0;
        repeat (2) @(negedge clk);
        chk("abort_no_resp", LINE_W'(resp_cnt - r0), LINE_W'(0));
        run_txn(1'b1, 1'b0, 1'b0, 32'h0000_5000, rand_line(), 16'hFFFF, 5);

        // Unaligned address handling.
        run_txn(1'b1, 1'b0, 1'b0, 32'h0000_1047, rand_line(), 16'h00AB, 0);
        run_txn(1'b0, 1'b1, 1'b0, 32'h0000_1047, rand_line(), 16'hFFFF, 0);

        // Random mix with random stall patterns.
        for (int n = 0; n < 6; n++) begin
            bit wr;
            wr = 1'($urandom_range(0, 1));
            run_txn(!wr, wr, 1'b0, $urandom(), rand_line(), 16'($urandom()), 0);
        end

        chk("queues_drained", LINE_W'(exp_line_q.size() + exp_beat_q.size()), LINE_W'(0));
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
